// File: rtl/sat_bin_pkg.sv
// Shared definitions for the bin-partitioned SAT engine control path.
// Holds the scheduler state encoding, the bin-index and level widths shared
// with the load/update stage, and the global result codes.
package sat_bin_pkg;

   localparam int BIN_IDX_W = 10;   // width of a bin index
   localparam int LVL_W     = 10;   // width of a decision/backtrack level

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_WAIT_LOAD = 3'd2,
      ST_RUN       = 3'd3,
      ST_WAIT_RUN  = 3'd4,
      ST_BKT       = 3'd5,
      ST_WAIT_BKT  = 3'd6,
      ST_FINISH    = 3'd7
   } sched_state_e;

   typedef enum logic [1:0] {
      RES_NONE  = 2'd0,
      RES_SAT   = 2'd1,
      RES_UNSAT = 2'd2,
      RES_ERR   = 2'd3
   } sched_res_e;

endpackage

// File: rtl/sched_watchdog.sv
// Wait-state watchdog for the bin scheduler.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   clr_i      : restart the count (asserted on entry to a wait state)
//   en_i       : currently waiting; the count advances once per cycle
//   expired_o  : high during the TIMEOUT_CYCLES-th consecutive wait cycle
module sched_watchdog #(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The count holds at LAST so a stalled enable can never wrap around.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The first wait cycle sees a count of 0, so LAST marks the final one.
   assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/bin_sched_ctrl.sv
// Bin scheduler for the bin-partitioned SAT engine. Walks the bins
// round-robin, asks the load/update stage to load each one, runs the SAT
// engine on it and reacts to bin SAT / conflict results. Declares global
// SAT after NUM_BINS consecutive bin SATs, UNSAT on a level-0 conflict,
// or an error when any wait state exceeds TIMEOUT_CYCLES.
// Ports:
//   clk, rst               : clock, synchronous active-low reset
//   start_i                : begin solving from bin 0 (IDLE/FINISH only)
//   start_load_update_o    : one-cycle load/update request
//   first_load_update_o    : qualifies the request; nothing to write back
//   request_bin_num_o      : bin to load, held until the next request
//   load_update_done_i     : load/update finished
//   start_bin_o            : one-cycle pulse; run the loaded bin
//   bin_sat_i              : bin satisfied
//   bin_conflict_i         : unresolvable conflict, level on bin_bkt_lvl_i
//   start_backtrack_o      : one-cycle backtrack request
//   bkt_lvl_o              : level of the most recent conflict
//   backtrack_done_i       : global backtrack finished
//   busy_o                 : solving (not IDLE, not FINISH)
//   done_o/sat_o/unsat_o/error_o : final result, held until next start_i
//   num_loads_o            : saturating count of load requests this solve
module bin_sched_ctrl
   import sat_bin_pkg::*;
#(
   parameter int NUM_BINS       = 16,
   parameter int WIDTH_BIN_I    = BIN_IDX_W,
   parameter int WIDTH_LVL      = LVL_W,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int WIDTH_STAT     = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   output logic                   start_load_update_o,
   output logic                   first_load_update_o,
   output logic [WIDTH_BIN_I-1:0] request_bin_num_o,
   input  logic                   load_update_done_i,
   output logic                   start_bin_o,
   input  logic                   bin_sat_i,
   input  logic                   bin_conflict_i,
   input  logic [WIDTH_LVL-1:0]   bin_bkt_lvl_i,
   output logic                   start_backtrack_o,
   output logic [WIDTH_LVL-1:0]   bkt_lvl_o,
   input  logic                   backtrack_done_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   sat_o,
   output logic                   unsat_o,
   output logic                   error_o,
   output logic [WIDTH_STAT-1:0]  num_loads_o
);

   localparam int STREAK_W = $clog2(NUM_BINS + 1);
   localparam logic [WIDTH_BIN_I-1:0] LAST_BIN    = WIDTH_BIN_I'(NUM_BINS - 1);
   localparam logic [STREAK_W-1:0]    FULL_STREAK = STREAK_W'(NUM_BINS);

   sched_state_e             state_q, state_d;
   logic [WIDTH_BIN_I-1:0]   cur_bin_q, cur_bin_d;
   logic [WIDTH_BIN_I-1:0]   req_bin_q, req_bin_d;
   logic [STREAK_W-1:0]      streak_q, streak_d;
   logic                     first_q, first_d;
   logic                     start_load_q, start_load_d;
   logic                     first_load_q, first_load_d;
   logic                     start_bin_q, start_bin_d;
   logic                     start_bkt_q, start_bkt_d;
   logic [WIDTH_LVL-1:0]     bkt_lvl_q, bkt_lvl_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     sat_q, sat_d;
   logic                     unsat_q, unsat_d;
   logic                     error_q, error_d;
   logic [WIDTH_STAT-1:0]    num_loads_q, num_loads_d;
   logic                     wd_clr, wd_en, wd_expired;
   sched_res_e               fin_res;

   sched_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (wd_clr),
      .en_i      (wd_en),
      .expired_o (wd_expired)
   );

   always_comb begin
      state_d      = state_q;
      cur_bin_d    = cur_bin_q;
      req_bin_d    = req_bin_q;
      streak_d     = streak_q;
      first_d      = first_q;
      start_load_d = 1'b0;
      first_load_d = 1'b0;
      start_bin_d  = 1'b0;
      start_bkt_d  = 1'b0;
      bkt_lvl_d    = bkt_lvl_q;
      done_d       = done_q;
      sat_d        = sat_q;
      unsat_d      = unsat_q;
      error_d      = error_q;
      num_loads_d  = num_loads_q;
      wd_clr       = 1'b0;
      wd_en        = 1'b0;
      fin_res      = RES_NONE;

      case (state_q)
         ST_IDLE, ST_FINISH: begin
            if (start_i) begin
               cur_bin_d   = '0;
               streak_d    = '0;
               first_d     = 1'b1;
               num_loads_d = '0;
               done_d      = 1'b0;
               sat_d       = 1'b0;
               unsat_d     = 1'b0;
               error_d     = 1'b0;
               state_d     = ST_LOAD;
            end
         end
         ST_LOAD: begin
            start_load_d = 1'b1;
            first_load_d = first_q;
            req_bin_d    = cur_bin_q;
            if (num_loads_q != '1) begin
               num_loads_d = num_loads_q + 1'b1;
            end
            first_d = 1'b0;
            wd_clr  = 1'b1;
            state_d = ST_WAIT_LOAD;
         end
         ST_WAIT_LOAD: begin
            wd_en = 1'b1;
            if (load_update_done_i) begin
               state_d = ST_RUN;
            end else if (wd_expired) begin
               fin_res = RES_ERR;
            end
         end
         ST_RUN: begin
            start_bin_d = 1'b1;
            wd_clr      = 1'b1;
            state_d     = ST_WAIT_RUN;
         end
         ST_WAIT_RUN: begin
            wd_en = 1'b1;
            // A conflict outranks a simultaneous bin SAT.
            if (bin_conflict_i) begin
               streak_d  = '0;
               bkt_lvl_d = bin_bkt_lvl_i;
               if (bin_bkt_lvl_i == '0) begin
                  fin_res = RES_UNSAT;
               end else begin
                  state_d = ST_BKT;
               end
            end else if (bin_sat_i) begin
               streak_d = streak_q + 1'b1;
               if ((streak_q + 1'b1) == FULL_STREAK) begin
                  fin_res = RES_SAT;
               end else begin
                  cur_bin_d = (cur_bin_q == LAST_BIN) ? '0 : cur_bin_q + 1'b1;
                  state_d   = ST_LOAD;
               end
            end else if (wd_expired) begin
               fin_res = RES_ERR;
            end
         end
         ST_BKT: begin
            start_bkt_d = 1'b1;
            wd_clr      = 1'b1;
            state_d     = ST_WAIT_BKT;
         end
         ST_WAIT_BKT: begin
            wd_en = 1'b1;
            // The same bin is reloaded so its learnt clauses are written back.
            if (backtrack_done_i) begin
               state_d = ST_LOAD;
            end else if (wd_expired) begin
               fin_res = RES_ERR;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (fin_res != RES_NONE) begin
         state_d = ST_FINISH;
         done_d  = 1'b1;
         sat_d   = (fin_res == RES_SAT);
         unsat_d = (fin_res == RES_UNSAT);
         error_d = (fin_res == RES_ERR);
      end

      busy_d = (state_d != ST_IDLE) && (state_d != ST_FINISH);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cur_bin_q    <= '0;
         req_bin_q    <= '0;
         streak_q     <= '0;
         first_q      <= 1'b1;
         start_load_q <= 1'b0;
         first_load_q <= 1'b0;
         start_bin_q  <= 1'b0;
         start_bkt_q  <= 1'b0;
         bkt_lvl_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         sat_q        <= 1'b0;
         unsat_q      <= 1'b0;
         error_q      <= 1'b0;
         num_loads_q  <= '0;
      end else begin
         state_q      <= state_d;
         cur_bin_q    <= cur_bin_d;
         req_bin_q    <= req_bin_d;
         streak_q     <= streak_d;
         first_q      <= first_d;
         start_load_q <= start_load_d;
         first_load_q <= first_load_d;
         start_bin_q  <= start_bin_d;
         start_bkt_q  <= start_bkt_d;
         bkt_lvl_q    <= bkt_lvl_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         sat_q        <= sat_d;
         unsat_q      <= unsat_d;
         error_q      <= error_d;
         num_loads_q  <= num_loads_d;
      end
   end

   assign start_load_update_o = start_load_q;
   assign first_load_update_o = first_load_q;
   assign request_bin_num_o   = req_bin_q;
   assign start_bin_o         = start_bin_q;
   assign start_backtrack_o   = start_bkt_q;
   assign bkt_lvl_o           = bkt_lvl_q;
   assign busy_o              = busy_q;
   assign done_o              = done_q;
   assign sat_o               = sat_q;
   assign unsat_o             = unsat_q;
   assign error_o             = error_q;
   assign num_loads_o         = num_loads_q;

endmodule

// File: doc/bin_sched_ctrl.md
Name: bin_sched_ctrl

Overview:
- Top-level bin scheduler for the bin-partitioned SAT engine. It sits directly upstream of the bin load/update stage and drives that stage's control inputs: start/first flags, requested bin number and backtrack request.
- It walks bins round-robin, runs the SAT engine on each loaded bin and reacts to the per-bin result (bin SAT, conflict with backtrack level).
- It declares global SAT, UNSAT or watchdog error.

Parameters:
- NUM_BINS, 16, number of bins in the problem (>=2)
- WIDTH_BIN_I, 10, width of the bin index
- WIDTH_LVL, 10, width of the decision/backtrack level
- TIMEOUT_CYCLES, 65535, watchdog limit per wait state
- WIDTH_STAT, 32, width of the load statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start_i  in  1  pulse; begin solving from bin 0
- start_load_update_o  out  1  one-cycle pulse to the load/update stage
- first_load_update_o  out  1  qualifies start pulse; no prior bin to write back
- request_bin_num_o  out  WIDTH_BIN_I  bin to load; stable from pulse until done
- load_update_done_i  in  1  pulse; load/update finished
- start_bin_o  out  1  one-cycle pulse; SAT engine runs the loaded bin
- bin_sat_i  in  1  pulse; all clauses of the bin satisfied
- bin_conflict_i  in  1  pulse; unresolvable conflict in the bin
- bin_bkt_lvl_i  in  WIDTH_LVL  backtrack level; valid with bin_conflict_i
- start_backtrack_o  out  1  one-cycle pulse to the load/update stage
- bkt_lvl_o  out  WIDTH_LVL  latched backtrack level; held until next conflict
- backtrack_done_i  in  1  pulse; global var-state backtrack complete
- busy_o  out  1  high in every state except IDLE and FINISH
- done_o  out  1  level; solve finished, held until next start_i
- sat_o  out  1  level; valid with done_o
- unsat_o  out  1  level; valid with done_o
- error_o  out  1  level; watchdog fired, valid with done_o
- num_loads_o  out  WIDTH_STAT  count of start_load_update_o pulses since start_i

Behaviour:
- Reset (rst==0 at posedge): state IDLE. All outputs 0. Bin index 0, sat_streak 0, first flag 1, watchdog 0. Reset mid-operation aborts immediately, with no further pulses.
- All outputs are registered. Pulses last exactly one cycle.
- FSM states: IDLE, LOAD, WAIT_LOAD, RUN, WAIT_RUN, BKT, WAIT_BKT, FINISH.
- IDLE / FINISH + start_i: cur_bin=0, sat_streak=0, first=1, num_loads=0; clear done/sat/unsat/error; go to LOAD. start_i in any other state is ignored.
- LOAD:
  - next cycle start_load_update_o=1, first_load_update_o=first, request_bin_num_o=cur_bin; num_loads+1 (saturating).
  - Clear first; go to WAIT_LOAD.
- WAIT_LOAD: on load_update_done_i go to RUN.
- RUN: start_bin_o pulse; go to WAIT_RUN.
- WAIT_RUN:
  - bin_conflict_i has priority over a simultaneous bin_sat_i.
  - On conflict: sat_streak=0, latch bkt_lvl_o=bin_bkt_lvl_i. If the level is 0, go to FINISH with unsat. Otherwise go to BKT.
  - On bin_sat_i: sat_streak+1. If the new value == NUM_BINS, go to FINISH with sat. Otherwise set cur_bin = (cur_bin==NUM_BINS-1)?0:cur_bin+1 and go to LOAD.
- BKT: start_backtrack_o pulse; go to WAIT_BKT.
- WAIT_BKT: on backtrack_done_i go to LOAD with cur_bin unchanged. The same bin is reloaded so its learnt clauses are written back and reloaded.
- FINISH: done_o=1 plus exactly one of sat_o, unsat_o or error_o. Outputs held.
- Watchdog:
  - Counter clears on entry to each WAIT_* state and increments while waiting.
  - At TIMEOUT_CYCLES: error_o=1 and go to FINISH.
  - A done/result pulse arriving in the same cycle as the timeout wins over the timeout.
- Stray input pulses (load_update_done_i, bin_sat_i, bin_conflict_i, backtrack_done_i) outside their matching WAIT state are ignored.
- Latency:
  - start_i to start_load_update_o: 2 cycles.
  - load_update_done_i to start_bin_o: 2 cycles.
  - bin_conflict_i to start_backtrack_o: 2 cycles.

Decomposition:
- Shared package sat_bin_pkg: state enumeration encodings; the WIDTH_BIN_I and WIDTH_LVL constants shared with the load/update stage; result code constants (SAT, UNSAT, ERR).
- One natural sub-module, sched_watchdog: clear/enable/expire counter parameterised by TIMEOUT_CYCLES.
- Everything else stays in one FSM file.

Test Plan:
1. NUM_BINS=4. start_i, every load done after 30 cycles, every bin returns bin_sat_i -> requests bins 0,1,2,3. first_load_update_o only on bin 0. Then done_o=1, sat_o=1, num_loads_o=4.
2. NUM_BINS=4. Bin 1 returns bin_conflict_i with level 3, backtrack done after 50 cycles -> start_backtrack_o once with bkt_lvl_o=3. Bin 1 reloaded with first_load_update_o=0. Streak restarts, so SAT requires bins 1,2,3,0 sat. num_loads_o=6.
3. Conflict with bin_bkt_lvl_i=0 on bin 2 -> no backtrack pulse, done_o=1, unsat_o=1, sat_o=0.
4. bin_sat_i and bin_conflict_i (level 5) in the same cycle -> treated as conflict; start_backtrack_o with bkt_lvl_o=5.
5. TIMEOUT_CYCLES=100, load_update_done_i never arrives -> error_o=1 and done_o=1 one cycle after the 100th wait cycle. A done pulse at cycle 100 instead gives a normal RUN.
6. rst=0 during WAIT_RUN -> all outputs 0 next cycle. start_i during busy is ignored. Stray backtrack_done_i in IDLE causes no change.
